// File: rtl/arbitro_vc_sched.sv
// Two-VC to two-destination scheduler: weighted VC0 priority with VC1 anti-starvation,
// almost-full back-pressure through a STALL state, and one-cycle pop-to-push routing.
module arbitro_vc_sched #(
  parameter int DATA_W      = 6,
  parameter int VC0_WEIGHT  = 3,
  parameter int RESUME_WAIT = 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              VC0_empty,
  input  logic              VC1_empty,
  input  logic [DATA_W-1:0] VC0_data,
  input  logic [DATA_W-1:0] VC1_data,
  input  logic              D0_almost_full,
  input  logic              D1_almost_full,
  input  logic              D0_full,
  input  logic              D1_full,
  output logic              VC0_pop,
  output logic              VC1_pop,
  output logic              D0_push,
  output logic              D1_push,
  output logic [DATA_W-1:0] data_out,
  output logic [1:0]        state,
  output logic              err_overflow
);

  localparam int WCNT_W = (VC0_WEIGHT < 1) ? 1 : $clog2(VC0_WEIGHT + 1);
  localparam int RCNT_W = (RESUME_WAIT < 1) ? 1 : $clog2(RESUME_WAIT + 1);
  localparam logic [WCNT_W-1:0] W_MAX  = WCNT_W'(VC0_WEIGHT);
  localparam logic [RCNT_W-1:0] R_WAIT = RCNT_W'(RESUME_WAIT);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SERVE = 2'd1,
    STALL = 2'd2
  } state_t;

  state_t            r_state;
  state_t            w_state_next;
  logic [WCNT_W-1:0] r_wcnt;
  logic [WCNT_W-1:0] w_wcnt_next;
  logic [RCNT_W-1:0] r_rcnt;
  logic [RCNT_W-1:0] w_rcnt_next;
  logic [RCNT_W-1:0] w_rcnt_inc;
  logic              r_pd0;
  logic              r_pd1;
  logic              r_err;

  logic              w_any_af;
  logic              w_pop_en;
  logic              w_grant0;
  logic              w_grant1;
  logic              w_valid;
  logic              w_to_d1;
  logic [1:0]        w_full;
  logic [1:0]        w_sel;
  logic [1:0]        w_push;
  logic [1:0]        w_ovf;

  assign w_any_af = D0_almost_full | D1_almost_full | D0_full | D1_full;
  assign w_pop_en = ~reset & (r_state != STALL) & ~w_any_af;

  // VC1 wins only once VC0 has used its weight, and wcnt clears on that grant
  assign w_grant0 = ~VC0_empty & (VC1_empty | (r_wcnt < W_MAX));
  assign w_grant1 = ~w_grant0 & ~VC1_empty;
  assign VC0_pop  = w_pop_en & w_grant0;
  assign VC1_pop  = w_pop_en & w_grant1;

  always_comb begin
    w_wcnt_next = r_wcnt;
    if (VC0_pop) begin
      if (r_wcnt != W_MAX) w_wcnt_next = r_wcnt + 1'b1;
    end else if (VC1_pop) begin
      w_wcnt_next = '0;
    end
  end

  assign w_rcnt_inc = r_rcnt + 1'b1;

  always_comb begin
    w_state_next = r_state;
    w_rcnt_next  = '0;
    if (w_any_af) begin
      w_state_next = STALL;
    end else if (r_state == STALL) begin
      if (w_rcnt_inc >= R_WAIT) begin
        w_state_next = IDLE;
      end else begin
        w_rcnt_next = w_rcnt_inc;
      end
    end else if (~VC0_empty | ~VC1_empty) begin
      w_state_next = SERVE;
    end else begin
      w_state_next = IDLE;
    end
  end

  // Source data arrives the cycle after the pop, selected by the registered pop flags
  assign w_valid  = r_pd0 | r_pd1;
  assign data_out = r_pd0 ? VC0_data : (r_pd1 ? VC1_data : '0);
  assign w_to_d1  = data_out[DATA_W-1];
  assign w_full   = {D1_full, D0_full};

  for (genvar gi = 0; gi < 2; gi++) begin : g_dest
    assign w_sel[gi]  = w_valid & (w_to_d1 == (gi == 1));
    assign w_push[gi] = ~reset & w_sel[gi] & ~w_full[gi];
    assign w_ovf[gi]  = w_sel[gi] & w_full[gi];
  end

  assign D0_push      = w_push[0];
  assign D1_push      = w_push[1];
  assign state        = r_state;
  assign err_overflow = r_err;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= IDLE;
      r_wcnt  <= '0;
      r_rcnt  <= '0;
      r_pd0   <= 1'b0;
      r_pd1   <= 1'b0;
      r_err   <= 1'b0;
    end else begin
      r_state <= w_state_next;
      r_wcnt  <= w_wcnt_next;
      r_rcnt  <= w_rcnt_next;
      r_pd0   <= VC0_pop;
      r_pd1   <= VC1_pop;
      r_err   <= r_err | (|w_ovf);
    end
  end

endmodule

// File: tb/tb_arbitro_vc_sched.sv
// Scenario bench for arbitro_vc_sched: expected words are queued when a pop is
// expected and compared when the push cycle arrives.
module tb_arbitro_vc_sched;
  localparam int DW = 6;

  logic          clk;
  logic          reset;
  logic          VC0_empty, VC1_empty;
  logic [DW-1:0] VC0_data, VC1_data;
  logic          D0_almost_full, D1_almost_full, D0_full, D1_full;
  logic          VC0_pop, VC1_pop, D0_push, D1_push;
  logic [DW-1:0] data_out;
  logic [1:0]    state;
  logic          err_overflow;

  int checks = 0;
  int errors = 0;
  logic [DW-1:0] exp_q[$];

  arbitro_vc_sched #(.DATA_W(DW), .VC0_WEIGHT(3), .RESUME_WAIT(2)) dut (
    .clk(clk), .reset(reset),
    .VC0_empty(VC0_empty), .VC1_empty(VC1_empty),
    .VC0_data(VC0_data), .VC1_data(VC1_data),
    .D0_almost_full(D0_almost_full), .D1_almost_full(D1_almost_full),
    .D0_full(D0_full), .D1_full(D1_full),
    .VC0_pop(VC0_pop), .VC1_pop(VC1_pop),
    .D0_push(D0_push), .D1_push(D1_push),
    .data_out(data_out), .state(state), .err_overflow(err_overflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    VC0_empty = 1'b1; VC1_empty = 1'b1;
    VC0_data = '0; VC1_data = '0;
    D0_almost_full = 1'b0; D1_almost_full = 1'b0;
    D0_full = 1'b0; D1_full = 1'b0;
  endtask

  task automatic do_reset();
    idle_inputs();
    reset = 1'b1;
    cyc();
    reset = 1'b0;
  endtask

  task automatic test_reset();
    idle_inputs();
    reset = 1'b1;
    VC0_empty = 1'b0; VC1_empty = 1'b0;
    @(negedge clk);
    checks++;
    if ({VC0_pop, VC1_pop} !== 2'b00) begin
      errors++; $display("FAIL reset_pop: got %b want 00", {VC0_pop, VC1_pop});
    end
    cyc();
    @(negedge clk);
    checks++;
    if ({state, data_out, err_overflow, D0_push, D1_push, VC0_pop, VC1_pop} !== '0) begin
      errors++;
      $display("FAIL reset_state: state=%0d data=%h err=%b push=%b%b pop=%b%b want all 0",
               state, data_out, err_overflow, D0_push, D1_push, VC0_pop, VC1_pop);
    end else $display("reset: outputs at reset values");
    cyc();
    reset = 1'b0;
    idle_inputs();
    cyc();
  endtask

  task automatic test_single_vc0();
    logic [DW-1:0] exp_w;
    do_reset();
    VC0_empty = 1'b0; VC0_data = 6'h05;
    @(negedge clk);
    checks++;
    if ({VC0_pop, VC1_pop} !== 2'b10) begin
      errors++; $display("FAIL single_pop: got %b want 10", {VC0_pop, VC1_pop});
    end
    exp_q.push_back(6'h05);
    cyc();
    VC0_empty = 1'b1;
    @(negedge clk);
    exp_w = exp_q.pop_front();
    checks++;
    if ({D0_push, D1_push} !== 2'b10 || data_out !== exp_w || state !== 2'd1) begin
      errors++;
      $display("FAIL single_push: push=%b%b data=%h state=%0d want push=10 data=%h state=1",
               D0_push, D1_push, data_out, state, exp_w);
    end else $display("single: D0 push data=%h", data_out);
    cyc();
    @(negedge clk);
    checks++;
    if (state !== 2'd0 || {VC0_pop, VC1_pop, D0_push, D1_push} !== 4'b0) begin
      errors++; $display("FAIL single_idle: state=%0d pop=%b%b want state=0 no pop", state, VC0_pop, VC1_pop);
    end
    cyc();
  endtask

  task automatic test_weight();
    logic [DW-1:0] exp_w;
    logic [1:0]    exp_p;
    logic [4:0]    tag;
    do_reset();
    VC0_empty = 1'b0; VC1_empty = 1'b0;
    for (int i = 0; i < 13; i++) begin
      tag = 5'(i - 1);
      VC0_data = {1'b0, tag};
      VC1_data = {1'b1, tag};
      if (i == 12) begin VC0_empty = 1'b1; VC1_empty = 1'b1; end
      @(negedge clk);
      if (i > 0) begin
        checks++;
        if (exp_q.size() == 0) begin
          errors++; $display("FAIL weight_push[%0d]: scoreboard empty", i);
        end else begin
          exp_w = exp_q.pop_front();
          if ({D0_push, D1_push} !== {~exp_w[DW-1], exp_w[DW-1]} || data_out !== exp_w) begin
            errors++;
            $display("FAIL weight_push[%0d]: push=%b%b data=%h want data=%h", i, D0_push, D1_push, data_out, exp_w);
          end else $display("weight: cycle %0d push D%0d data=%h", i, exp_w[DW-1], data_out);
        end
      end
      if (i < 12) begin
        exp_p = (i % 4 == 3) ? 2'b01 : 2'b10;
        checks++;
        if ({VC0_pop, VC1_pop} !== exp_p) begin
          errors++; $display("FAIL weight_pop[%0d]: got %b want %b", i, {VC0_pop, VC1_pop}, exp_p);
        end
        exp_q.push_back(exp_p[1] ? {1'b0, 5'(i)} : {1'b1, 5'(i)});
      end
      if (i == 5) begin
        checks++;
        if (state !== 2'd1) begin
          errors++; $display("FAIL weight_state: got %0d want 1", state);
        end
      end
      cyc();
    end
  endtask

  task automatic test_af_stall();
    logic [DW-1:0] exp_w;
    do_reset();
    VC1_empty = 1'b0;
    @(negedge clk);
    checks++;
    if ({VC0_pop, VC1_pop} !== 2'b01) begin
      errors++; $display("FAIL stall_pop: got %b want 01", {VC0_pop, VC1_pop});
    end
    exp_q.push_back(6'h21);
    cyc();
    D1_almost_full = 1'b1; VC1_data = 6'h21;
    @(negedge clk);
    exp_w = exp_q.pop_front();
    checks++;
    if ({VC0_pop, VC1_pop} !== 2'b00 || {D0_push, D1_push} !== 2'b01 || data_out !== exp_w) begin
      errors++;
      $display("FAIL stall_inflight: pop=%b%b push=%b%b data=%h want pop=00 push=01 data=%h",
               VC0_pop, VC1_pop, D0_push, D1_push, data_out, exp_w);
    end else $display("stall: in-flight D1 push data=%h", data_out);
    cyc();
    D1_almost_full = 1'b0; VC1_data = '0;
    for (int k = 0; k < 2; k++) begin
      @(negedge clk);
      checks++;
      if (state !== 2'd2 || {VC0_pop, VC1_pop, D0_push, D1_push} !== 4'b0) begin
        errors++; $display("FAIL stall_hold[%0d]: state=%0d pop=%b%b want state=2 no pop", k, state, VC0_pop, VC1_pop);
      end
      cyc();
    end
    @(negedge clk);
    checks++;
    if (state !== 2'd0 || {VC0_pop, VC1_pop} !== 2'b01) begin
      errors++; $display("FAIL stall_resume: state=%0d pop=%b%b want state=0 pop=01", state, VC0_pop, VC1_pop);
    end
    exp_q.push_back(6'h22);
    cyc();
    VC1_empty = 1'b1; VC1_data = 6'h22;
    @(negedge clk);
    exp_w = exp_q.pop_front();
    checks++;
    if ({D0_push, D1_push} !== 2'b01 || data_out !== exp_w) begin
      errors++; $display("FAIL stall_after: push=%b%b data=%h want push=01 data=%h", D0_push, D1_push, data_out, exp_w);
    end else $display("stall: resumed D1 push data=%h", data_out);
    cyc();
  endtask

  task automatic test_af_toggle();
    logic [DW-1:0] exp_w;
    logic [1:0]    exp_s;
    do_reset();
    VC0_empty = 1'b0; VC0_data = 6'h03;
    for (int k = 0; k < 5; k++) begin
      D0_almost_full = (k == 0);
      D1_full        = (k == 2);
      exp_s          = (k == 0) ? 2'd0 : 2'd2;
      @(negedge clk);
      checks++;
      if (state !== exp_s || {VC0_pop, VC1_pop, D0_push, D1_push} !== 4'b0) begin
        errors++; $display("FAIL toggle[%0d]: state=%0d pop=%b%b want state=%0d no pop", k, state, VC0_pop, VC1_pop, exp_s);
      end
      cyc();
    end
    D0_almost_full = 1'b0; D1_full = 1'b0;
    @(negedge clk);
    checks++;
    if (state !== 2'd0 || {VC0_pop, VC1_pop} !== 2'b10 || err_overflow !== 1'b0) begin
      errors++; $display("FAIL toggle_resume: state=%0d pop=%b%b err=%b want state=0 pop=10 err=0", state, VC0_pop, VC1_pop, err_overflow);
    end
    exp_q.push_back(6'h03);
    cyc();
    VC0_empty = 1'b1;
    @(negedge clk);
    exp_w = exp_q.pop_front();
    checks++;
    if ({D0_push, D1_push} !== 2'b10 || data_out !== exp_w) begin
      errors++; $display("FAIL toggle_push: push=%b%b data=%h want push=10 data=%h", D0_push, D1_push, data_out, exp_w);
    end else $display("toggle: D0 push data=%h", data_out);
    cyc();
  endtask

  task automatic test_overflow();
    logic [DW-1:0] exp_w;
    do_reset();
    VC1_empty = 1'b0;
    @(negedge clk);
    checks++;
    if ({VC0_pop, VC1_pop} !== 2'b01) begin
      errors++; $display("FAIL ovf_pop: got %b want 01", {VC0_pop, VC1_pop});
    end
    exp_q.push_back(6'h20);
    cyc();
    VC1_empty = 1'b1; VC1_data = 6'h20; D1_full = 1'b1;
    @(negedge clk);
    exp_w = exp_q.pop_front();
    checks++;
    if ({D0_push, D1_push} !== 2'b00 || data_out !== exp_w || err_overflow !== 1'b0) begin
      errors++;
      $display("FAIL ovf_drop: push=%b%b data=%h err=%b want push=00 data=%h err=0",
               D0_push, D1_push, data_out, err_overflow, exp_w);
    end else $display("overflow: word %h dropped at full D1", data_out);
    cyc();
    D1_full = 1'b0; VC1_data = '0;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      checks++;
      if (err_overflow !== 1'b1) begin
        errors++; $display("FAIL ovf_sticky[%0d]: err=%b want 1", k, err_overflow);
      end
      cyc();
    end
    do_reset();
    @(negedge clk);
    checks++;
    if (err_overflow !== 1'b0) begin
      errors++; $display("FAIL ovf_clear: err=%b want 0", err_overflow);
    end
    cyc();
  endtask

  task automatic test_reset_midflight();
    do_reset();
    VC0_empty = 1'b0; VC0_data = 6'h07;
    @(negedge clk);
    checks++;
    if ({VC0_pop, VC1_pop} !== 2'b10) begin
      errors++; $display("FAIL midrst_pop: got %b want 10", {VC0_pop, VC1_pop});
    end
    cyc();
    reset = 1'b1; VC0_empty = 1'b1;
    @(negedge clk);
    checks++;
    if ({VC0_pop, VC1_pop, D0_push, D1_push} !== 4'b0) begin
      errors++; $display("FAIL midrst_during: pop=%b%b push=%b%b want all 0", VC0_pop, VC1_pop, D0_push, D1_push);
    end
    cyc();
    reset = 1'b0;
    @(negedge clk);
    checks++;
    if ({D0_push, D1_push} !== 2'b00 || data_out !== '0 || state !== 2'd0 || err_overflow !== 1'b0) begin
      errors++;
      $display("FAIL midrst_after: push=%b%b data=%h state=%0d err=%b want all 0",
               D0_push, D1_push, data_out, state, err_overflow);
    end else $display("midflight reset: in-flight word discarded");
    cyc();
  endtask

  initial begin
    test_reset();
    test_single_vc0();
    test_weight();
    test_af_stall();
    test_af_toggle();
    test_overflow();
    test_reset_midflight();
    checks++;
    if (exp_q.size() != 0) begin
      errors++; $display("FAIL scoreboard_drain: %0d words left, want 0", exp_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/arbitro_vc_sched.md
ARBITRO_VC_SCHED -- requirements
Module: arbitro_vc_sched

Interface
REQ-001 SHALL have parameter DATA_W, default 6: width of VC and output data words.
REQ-002 SHALL have parameter VC0_WEIGHT, default 3: maximum consecutive VC0 grants while VC1 is non-empty.
REQ-003 SHALL have parameter RESUME_WAIT, default 2: consecutive cycles with no almost-full required before leaving STALL.
REQ-004 clk  in  1  single clock; all state updates on rising edge.
REQ-005 reset  in  1  synchronous, active-high reset.
REQ-006 VC0_empty, VC1_empty  in  1 each  source FIFO empty flags.
REQ-007 VC0_data, VC1_data  in  DATA_W each  source FIFO read data, valid the cycle after a pop.
REQ-008 D0_almost_full, D1_almost_full  in  1 each  destination FIFO almost-full; each guarantees room for at least one more word.
REQ-009 D0_full, D1_full  in  1 each  destination FIFO full flags.
REQ-010 VC0_pop, VC1_pop  out  1 each  combinational pop strobes to source FIFOs.
REQ-011 D0_push, D1_push  out  1 each  push strobes to destination FIFOs.
REQ-012 data_out  out  DATA_W  word driven to destination FIFOs.
REQ-013 state  out  2  FSM state: IDLE=0, SERVE=1, STALL=2.
REQ-014 err_overflow  out  1  sticky: a push was attempted into a full destination.

Function
REQ-015 any_af = D0_almost_full | D1_almost_full | D0_full | D1_full.
REQ-016 Pops SHALL be enabled only when reset=0, state != STALL and any_af=0.
REQ-017 When enabled, at most one of VC0_pop/VC1_pop SHALL be high per cycle; never pop an empty VC.
REQ-018 Grant choice: VC0 if VC0 non-empty and (VC1 empty or wcnt < VC0_WEIGHT); else VC1 if VC1 non-empty; else none.
REQ-019 wcnt (counter, saturating at VC0_WEIGHT) SHALL increment on each VC0_pop and clear on each VC1_pop; it holds otherwise.
REQ-020 VC1 SHALL be granted at most one cycle at a time when VC0 is non-empty (strict VC0 priority with VC1 anti-starvation).
REQ-021 FSM transitions, evaluated each clock, in priority order: any_af=1 -> STALL from any state; in STALL, stay until any_af=0 for RESUME_WAIT consecutive cycles, then -> IDLE; otherwise -> SERVE if either VC is non-empty, else IDLE.
REQ-022 STALL resume counter SHALL clear whenever any_af=1 and count only in STALL.
REQ-023 Registers pd0 <= VC0_pop and pd1 <= VC1_pop; output valid v = pd0 | pd1, i.e. 1-cycle pop-to-push latency.
REQ-024 data_out = VC0_data when pd0, VC1_data when pd1, else all zeros.
REQ-025 Routing: when v=1, data_out[DATA_W-1]=0 targets D0 and data_out[DATA_W-1]=1 targets D1.
REQ-026 D0_push = v & ~data_out[DATA_W-1] & ~D0_full; D1_push = v & data_out[DATA_W-1] & ~D1_full.
REQ-027 If v=1 and the targeted destination is full, the push SHALL be suppressed, the word dropped, and err_overflow set on the next edge.
REQ-028 A word popped in the cycle almost-full first rises SHALL still be pushed the following cycle (in-flight word absorbed by almost-full margin).

Reset
REQ-029 While reset=1: VC0_pop=VC1_pop=0 combinationally, D0_push=D1_push=0.
REQ-030 After a reset edge: state=IDLE, wcnt=0, resume counter=0, pd0=pd1=0, data_out=0, err_overflow=0.
REQ-031 Reset asserted mid-operation SHALL discard any in-flight word; no push in the cycle after the reset edge.

Verification
REQ-032 Reset then VC0 non-empty (data 6'h05), VC1 empty, no af -> VC0_pop=1 in cycle N, D0_push=1 with data_out=6'h05 in N+1, state=SERVE.
REQ-033 Both VCs continuously non-empty, VC0_WEIGHT=3 -> pop pattern VC0,VC0,VC0,VC1 repeating.
REQ-034 D1_almost_full rises in the same cycle as a VC1 pop of 6'h21 -> pop drops immediately, D1_push of 6'h21 next cycle, state=STALL, pops resume after 2 clear cycles.
REQ-035 af toggles 1,0,1,0 in STALL -> state stays STALL and no pops until two consecutive clear cycles.
REQ-036 Pop of 6'h20 with D1_full=1 at push cycle -> D1_push=0, err_overflow=1 and sticky until reset.
REQ-037 reset=1 for one cycle one cycle after a pop -> no push, all outputs at reset values.
